ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch stage that owns the architectural program counter of the MIPS core. Each cycle it can accept the next-PC value produced by the next-PC logic. It fetches the instruction at the current PC from instruction memory over a request/grant/response handshake, then holds that instruction stable for decode and execute until the core commits the next PC. It sits directly downstream of the next-PC computation, consuming `npc`, and upstream of decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `npc`  in  32: next PC from the next-PC logic.
- `npc_en`  in  1: commit strobe. Loads `npc` into PC; honoured only in HOLD.
- `pc`  out  32: current PC; registered.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; equals `pc`.
- `imem_gnt`  in  1: memory accepts the request in this cycle.
- `imem_rvalid`  in  1: response data valid.
- `imem_rdata`  in  32: response instruction word.
- `instr`  out  32: fetched instruction; registered.
- `instr_valid`  out  1: `instr` holds the word at `pc`.
- `misalign_err`  out  1: sticky; a committed `npc` had `npc[1:0]` != 0.
- `fetch_cnt`  out  32: number of completed fetches; wraps modulo 2^32.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, HALT.
- Reset (`rst`=1 at an edge) sets:
  - state=IDLE, `pc`=`RESET_PC`, `instr`=0
  - `instr_valid`=0, `misalign_err`=0, `fetch_cnt`=0
- `imem_req` = (state==REQ); it is 0 in every other state, including while `rst` is high.
- `imem_addr` = `pc` in all states.
- IDLE: go to REQ unconditionally on the next edge.
- REQ: `imem_req`=1.
  - `imem_gnt`=1 → WAIT.
  - `imem_gnt`=0 → stay in REQ with `imem_addr` held stable.
  - `imem_rvalid` is ignored in REQ.
- WAIT: on `imem_rvalid`=1:
  - `instr`<=`imem_rdata`, `instr_valid`<=1, `fetch_cnt`<=`fetch_cnt`+1, → HOLD.
  - Otherwise stay in WAIT; there is no timeout.
- HOLD: `instr` and `pc` are stable. On `npc_en`=1:
  - `npc[1:0]`==0: `pc`<=`npc`, `instr_valid`<=0, → REQ.
  - `npc[1:0]`!=0: `pc` is unchanged, `instr_valid`<=0, `misalign_err`<=1, → HALT.
- `npc_en` is ignored in IDLE, REQ, WAIT and HALT. `pc` is never modified in those states.
- HALT: absorbing state. No requests are issued and `instr_valid`=0. Only `rst` leaves HALT.
- `npc` equal to the current `pc` (a self-loop) is legal and causes a fresh fetch of the same address.
- `imem_rdata` is captured without modification. Only word-aligned fetches are ever issued.

## Timing
- Minimum fetch latency: REQ with `imem_gnt`=1 in cycle t, then `imem_rvalid`=1 in cycle t+1. `instr_valid` rises at the edge ending t+1.
- `imem_rvalid` in the same cycle as the grant is not supported. The memory must return data no earlier than the cycle after `imem_gnt`.
- Best-case loop is 3 cycles per instruction (REQ, WAIT, HOLD with `npc_en` asserted).
- Commit: `npc_en` in HOLD cycle t gives a new `pc` at the edge ending t, with `imem_req`=1 and `imem_addr`=new `pc` in cycle t+1.
- After reset deasserts:
  - Cycle 0 is IDLE, with `imem_req`=0.
  - Cycle 1 is REQ, with `imem_addr`=`RESET_PC`.
- Reset mid-fetch (in WAIT or REQ) abandons the transaction. A stale `imem_rvalid` arriving in IDLE or REQ afterwards is ignored and `fetch_cnt` does not increment.
- `rst` takes priority over every other input at the same edge, including `npc_en` and `imem_rvalid`.
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0 without side effects.

## Test plan
- Reset, with `RESET_PC`=32'h0000_3000 → cycle 0 `imem_req`=0. Cycle 1 `imem_req`=1 and `imem_addr`=32'h0000_3000. `pc`, `instr`, `instr_valid` and `fetch_cnt` all read 0 except `pc`=32'h0000_3000.
- Zero-wait memory (`gnt` in REQ, `rvalid` the next cycle, `rdata`=32'h2008_0005), `npc_en`=1 with `npc`=32'h0000_3004 in HOLD → `instr`=32'h2008_0005, `fetch_cnt`=1. New request to 32'h0000_3004 in the cycle after the commit, for a 3-cycle loop.
- `imem_gnt` held low for 4 cycles, then a 2-cycle response delay → `imem_addr` stable throughout, `instr_valid` only after `rvalid`. `npc_en` pulses during REQ and WAIT leave `pc` unchanged.
- In HOLD, `npc_en`=1 with `npc`=32'h0000_3002 → `misalign_err`=1, `pc` unchanged, state HALT, `imem_req` stays 0 for 10+ cycles. A following `rst` clears `misalign_err` and refetches `RESET_PC`.
- `rst` asserted during WAIT, then `imem_rvalid`=1 in the first post-reset cycle → `instr_valid` stays 0, `fetch_cnt`=0, and a normal fetch of `RESET_PC` follows.
- `npc`=`pc` commit in HOLD → the same address is refetched and `fetch_cnt` increments by 1 per loop.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid
// handshake and holds the fetched word until the core commits the next PC.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        npc_en,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] cnt_nxt;
  logic        iv_nxt;
  logic        me_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr        <= instr_nxt;
      instr_valid  <= iv_nxt;
      misalign_err <= me_nxt;
      fetch_cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    iv_nxt    = instr_valid;
    me_nxt    = misalign_err;
    cnt_nxt   = fetch_cnt;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_nxt = imem_rdata;
          iv_nxt    = 1'b1;
          cnt_nxt   = fetch_cnt + 32'd1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (npc_en) begin
          iv_nxt = 1'b0;
          // A misaligned target is never fetched; the core parks in HALT.
          if (npc[1:0] == 2'b00) begin
            pc_nxt    = npc;
            state_nxt = REQ;
          end else begin
            me_nxt    = 1'b1;
            state_nxt = HALT;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so no request leaks out while reset is being applied.
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_ifetch_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_HOLD = 3;
  localparam int P_HALT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        npc_en;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  ifetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .npc          (npc),
    .npc_en       (npc_en),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  int          ph;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_iv;
  logic        m_me;
  logic [31:0] m_cnt;
  bit          m_known = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2008_0005;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic en, input logic [31:0] n,
                      input logic g, input logic rv, input logic [31:0] rd);
    rst = r; npc_en = en; npc = n;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    #1;
    if (m_known) begin
      check("imem_req",     {31'b0, imem_req},     {31'b0, (ph == P_REQ) && !r});
      check("imem_addr",    imem_addr,             m_pc);
      check("pc",           pc,                    m_pc);
      check("instr",        instr,                 m_instr);
      check("instr_valid",  {31'b0, instr_valid},  {31'b0, m_iv});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_me});
      check("fetch_cnt",    fetch_cnt,             m_cnt);
    end
    @(posedge clk);
    if (r) begin
      ph = P_IDLE; m_pc = RPC; m_instr = '0; m_iv = 0; m_me = 0; m_cnt = '0;
      m_known = 1;
    end else begin
      case (ph)
        P_IDLE: ph = P_REQ;
        P_REQ:  if (g) ph = P_WAIT;
        P_WAIT: if (rv) begin
          m_instr = rd; m_iv = 1; m_cnt = m_cnt + 1; ph = P_HOLD;
        end
        P_HOLD: if (en) begin
          m_iv = 0;
          if (n[1:0] == 2'b00) begin m_pc = n; ph = P_REQ; end
          else begin m_me = 1; ph = P_HALT; end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    logic        r, en, g, rv;
    logic [31:0] n, rd;
    int          k;

    // Reset, then zero-wait fetch of RESET_PC and commit to 0x3004
    step(1, 0, '0, 0, 0, '0);
    step(1, 1, 32'h0000_1000, 1, 1, 32'hDEAD_BEEF);
    step(0, 0, '0, 1, 0, '0);                       // IDLE
    step(0, 0, '0, 1, 0, '0);                       // REQ, granted
    step(0, 0, '0, 0, 1, 32'h2008_0005);            // WAIT, response
    step(0, 1, 32'h0000_3004, 0, 0, '0);            // HOLD, commit
    check("instr_after_commit", instr, 32'h2008_0005);
    check("cnt_after_first",    fetch_cnt, 32'd1);

    // Grant held off 4 cycles, npc_en pulses ignored in REQ and WAIT
    for (int i = 0; i < 4; i++) step(0, i[0], 32'h0000_7000, 0, 0, '0);
    step(0, 0, '0, 1, 0, '0);
    step(0, 1, 32'h0000_8000, 0, 0, '0);
    step(0, 0, '0, 0, 0, '0);
    step(0, 0, '0, 0, 1, memword(32'h0000_3004));
    check("pc_stable", pc, 32'h0000_3004);

    // Misaligned commit -> HALT, no requests for 12 cycles, then reset
    step(0, 1, 32'h0000_3002, 0, 0, '0);
    for (int i = 0; i < 12; i++) step(0, 1, 32'h0000_4000, 1, 1, 32'h1234_5678);
    step(1, 0, '0, 0, 0, '0);
    step(0, 0, '0, 0, 0, '0);
    step(0, 0, '0, 1, 0, '0);

    // Reset during WAIT, stale rvalid in first post-reset cycle
    step(1, 0, '0, 0, 1, 32'hBAD0_BAD0);
    step(0, 0, '0, 0, 1, 32'hBAD1_BAD1);            // IDLE: stale response
    step(0, 0, '0, 0, 1, 32'hBAD2_BAD2);            // REQ: ignored
    step(0, 0, '0, 1, 0, '0);
    step(0, 0, '0, 0, 1, memword(RPC));

    // Self-loop commits refetch the same address
    for (int i = 0; i < 3; i++) begin
      step(0, 1, RPC, 0, 0, '0);
      step(0, 0, '0, 1, 0, '0);
      step(0, 0, '0, 0, 1, memword(RPC));
    end
    check("selfloop_cnt", fetch_cnt, 32'd4);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      g  = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      rd = (ph == P_WAIT) ? memword(m_pc) : $urandom;
      en = ($urandom_range(0, 3) == 0);
      k  = $urandom_range(0, 15);
      if (k == 0)      n = m_pc + 32'($urandom_range(1, 3));
      else if (k == 1) n = m_pc;
      else if (k == 2) n = $urandom & 32'hFFFF_FFFC;
      else             n = m_pc + 32'd4;
      r = ($urandom_range(0, 199) == 0) || (ph == P_HALT && $urandom_range(0, 7) == 0);
      step(r, en, n, g, rv, rd);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
